// File: rtl/ysyx_24110006_pkg.sv
// Shared definitions for the load/store unit.
// Contents: FSM state encodings, load funct3 codes, unshifted store masks,
// AXI response codes and a response-to-fault helper.
package ysyx_24110006_pkg;

    // FSM state encodings
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Unshifted store byte masks
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Any response other than OKAY (including EXOKAY) is reported as a fault.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY:   err = 1'b0;
            RESP_SLVERR: err = 1'b1;
            RESP_DECERR: err = 1'b1;
            default:     err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/ysyx_24110006_lsu_align.sv
// Combinational lane logic for the LSU.
// Ports:
//   req_*    : incoming request (offset, store data/mask, load funct3, ren/wen)
//   st_wdata : store data shifted into its byte lanes
//   st_wstrb : store strobe shifted into its byte lanes (4-bit, truncated)
//   req_fault: misaligned, unsupported funct3, bad mask, or ren and wen together
//   ld_*     : captured load offset/funct3 and raw bus word -> extended result
import ysyx_24110006_pkg::*;

module ysyx_24110006_lsu_align (
    input  logic [1:0]  req_off,
    input  logic [31:0] req_src,
    input  logic [3:0]  req_mask,
    input  logic [2:0]  req_funct3,
    input  logic        req_ren,
    input  logic        req_wen,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic        req_fault,
    input  logic [1:0]  ld_off,
    input  logic [2:0]  ld_funct3,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift_s;
    logic        ld_bad_s;
    logic        st_bad_s;

    // Store lane placement: data and strobe move up by the byte offset.
    always_comb begin
        st_wdata = req_src << {req_off, 3'b000};
        st_wstrb = req_mask << req_off;
    end

    // Load lane selection followed by sign/zero extension.
    always_comb begin
        ld_shift_s = ld_raw >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
            F3_LH:   ld_data = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
            F3_LW:   ld_data = ld_shift_s;
            F3_LBU:  ld_data = {24'h000000, ld_shift_s[7:0]};
            F3_LHU:  ld_data = {16'h0000, ld_shift_s[15:0]};
            default: ld_data = 32'h0000_0000;
        endcase
    end

    // Fault detection; stores derive their access size from the mask.
    always_comb begin
        case (req_funct3)
            F3_LB, F3_LBU: ld_bad_s = 1'b0;
            F3_LH, F3_LHU: ld_bad_s = req_off[0];
            F3_LW:         ld_bad_s = (req_off != 2'b00);
            default:       ld_bad_s = 1'b1;
        endcase
        case (req_mask)
            MASK_B:  st_bad_s = 1'b0;
            MASK_H:  st_bad_s = req_off[0];
            MASK_W:  st_bad_s = (req_off != 2'b00);
            default: st_bad_s = 1'b1;
        endcase
        req_fault = (req_ren & req_wen) | (req_ren & ld_bad_s) | (req_wen & st_bad_s);
    end

endmodule

// File: rtl/ysyx_24110006_lsu.sv
// Load/store unit: captures one request from execute, runs a single AXI4-Lite
// read or write transaction, and pulses o_valid toward writeback.
// Ports:
//   i_clock, i_reset (sync, active low)
//   i_valid/i_addr/i_wdata/i_mem_ren/i_mem_wen/i_wmask/i_read_t : request
//   o_valid/o_rdata/o_err : one-cycle completion with extended load data
//   ar*/r*/aw*/w*/b* : AXI4-Lite master channels
import ysyx_24110006_pkg::*;

module ysyx_24110006_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_mem_ren,
    input  logic                  i_mem_wen,
    input  logic [3:0]            i_wmask,
    input  logic [2:0]            i_read_t,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_err,
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    logic [2:0]        state_r;
    logic [1:0]        off_r;
    logic [2:0]        funct3_r;
    logic              aw_done_r;
    logic              w_done_r;

    logic [31:0]       st_wdata_s;
    logic [3:0]        st_wstrb_s;
    logic              req_fault_s;
    logic [31:0]       ld_data_s;
    logic              aw_hs_s;
    logic              w_hs_s;
    logic              aw_done_s;
    logic              w_done_s;

    ysyx_24110006_lsu_align u_align (
        .req_off    (i_addr[1:0]),
        .req_src    (i_wdata),
        .req_mask   (i_wmask),
        .req_funct3 (i_read_t),
        .req_ren    (i_mem_ren),
        .req_wen    (i_mem_wen),
        .st_wdata   (st_wdata_s),
        .st_wstrb   (st_wstrb_s),
        .req_fault  (req_fault_s),
        .ld_off     (off_r),
        .ld_funct3  (funct3_r),
        .ld_raw     (rdata),
        .ld_data    (ld_data_s)
    );

    // Write-channel handshakes; the done flags let aw and w finish in any order.
    always_comb begin
        aw_hs_s   = awvalid & awready;
        w_hs_s    = wvalid & wready;
        aw_done_s = aw_done_r | aw_hs_s;
        w_done_s  = w_done_r | w_hs_s;
    end

    // Main FSM with all outputs registered.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_r   <= S_IDLE;
            off_r     <= 2'b00;
            funct3_r  <= 3'b000;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            o_valid   <= 1'b0;
            o_rdata   <= '0;
            o_err     <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (i_valid) begin
                        off_r     <= i_addr[1:0];
                        funct3_r  <= i_read_t;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        if (req_fault_s) begin
                            state_r <= S_DONE;
                            o_valid <= 1'b1;
                            o_err   <= 1'b1;
                            o_rdata <= '0;
                        end else if (i_mem_ren) begin
                            state_r <= S_AR;
                            arvalid <= 1'b1;
                            araddr  <= {i_addr[ADDR_W-1:2], 2'b00};
                        end else if (i_mem_wen) begin
                            state_r <= S_WR;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            awaddr  <= {i_addr[ADDR_W-1:2], 2'b00};
                            wdata   <= st_wdata_s;
                            wstrb   <= st_wstrb_s;
                        end else begin
                            // Non-memory instruction: complete next cycle.
                            state_r <= S_DONE;
                            o_valid <= 1'b1;
                            o_err   <= 1'b0;
                            o_rdata <= '0;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_r <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        rready  <= 1'b0;
                        o_rdata <= ld_data_s;
                        o_err   <= resp_is_err(rresp);
                        o_valid <= 1'b1;
                        state_r <= S_DONE;
                    end
                end
                S_WR: begin
                    if (aw_hs_s) begin
                        awvalid <= 1'b0;
                    end
                    if (w_hs_s) begin
                        wvalid <= 1'b0;
                    end
                    aw_done_r <= aw_done_s;
                    w_done_r  <= w_done_s;
                    if (aw_done_s && w_done_s) begin
                        bready  <= 1'b1;
                        state_r <= S_B;
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        o_err   <= resp_is_err(bresp);
                        o_rdata <= '0;
                        o_valid <= 1'b1;
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    arvalid <= 1'b0;
                    rready  <= 1'b0;
                    awvalid <= 1'b0;
                    wvalid  <= 1'b0;
                    bready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
module tb_ysyx_24110006_lsu;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_mem_ren;
    logic        i_mem_wen;
    logic [3:0]  i_wmask;
    logic [2:0]  i_read_t;
    logic        o_valid;
    logic [31:0] o_rdata;
    logic        o_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 i_clock = ~i_clock;

    ysyx_24110006_lsu dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen),
        .i_wmask(i_wmask), .i_read_t(i_read_t), .o_valid(o_valid),
        .o_rdata(o_rdata), .o_err(o_err), .araddr(araddr), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wsrc;
        logic [3:0]  wmask;
        logic [2:0]  f3;
        int          ar_d, r_d, aw_d, w_d, b_d;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        exp_ld;
        logic        exp_st;
        logic [31:0] exp_baddr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [31:0] slave_mem [16];
    logic [31:0] model_mem [16];

    int          obs_ov, obs_lat, obs_ar, obs_r, obs_aw, obs_w, obs_b;
    logic [31:0] obs_rdata, obs_baddr, obs_wdata;
    logic        obs_err;
    logic [3:0]  obs_wstrb;

    vec_t tbl [15];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] wsrc,
        input logic [3:0] wmask, input logic [2:0] f3,
        input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d,
        input logic [1:0] resp, input logic [31:0] exp_rdata, input logic exp_err,
        input int exp_lat, input logic exp_ld, input logic exp_st,
        input logic [31:0] exp_baddr, input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
        vec_t v;
        v.ren = ren; v.wen = wen; v.addr = addr; v.wsrc = wsrc; v.wmask = wmask; v.f3 = f3;
        v.ar_d = ar_d; v.r_d = r_d; v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.resp = resp;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_ld = exp_ld; v.exp_st = exp_st; v.exp_baddr = exp_baddr;
        v.exp_wdata = exp_wdata; v.exp_wstrb = exp_wstrb;
        return v;
    endfunction

    // Reference model: byte-level memory and plain arithmetic on the request.
    function automatic void model_write(input logic [31:0] addr, input logic [31:0] src, input logic [3:0] mask);
        int off = int'(addr % 32'd4);
        int idx = int'((addr / 32'd4) % 32'd16);
        for (int j = 0; j < 4; j++) begin
            if (j >= off && mask[j - off]) begin
                model_mem[idx] = (model_mem[idx] & ~(32'hFF << (8 * j)))
                               | (((src >> (8 * (j - off))) & 32'hFF) << (8 * j));
            end
        end
    endfunction

    function automatic void model_expect(inout vec_t v);
        int off = int'(v.addr % 32'd4);
        int idx = int'((v.addr / 32'd4) % 32'd16);
        bit bad;
        logic [31:0] d, b, h;
        if (v.ren && v.wen)
            bad = 1'b1;
        else if (v.ren)
            bad = (v.f3 == 3'd3 || v.f3 == 3'd6 || v.f3 == 3'd7)
               || ((v.f3 == 3'd1 || v.f3 == 3'd5) && (off % 2 != 0))
               || (v.f3 == 3'd2 && off != 0);
        else if (v.wen)
            bad = !(v.wmask == 4'd1 || (v.wmask == 4'd3 && off % 2 == 0) || (v.wmask == 4'd15 && off == 0));
        else
            bad = 1'b0;
        v.exp_rdata = 32'd0; v.exp_err = 1'b0; v.exp_lat = 1; v.exp_ld = 1'b0; v.exp_st = 1'b0;
        v.exp_baddr = 32'd0; v.exp_wdata = 32'd0; v.exp_wstrb = 4'd0;
        if (bad) begin
            v.exp_err = 1'b1;
        end else if (v.ren) begin
            d = model_mem[idx] >> (8 * off);
            b = d & 32'hFF;
            h = d & 32'hFFFF;
            case (v.f3)
                3'd0:    v.exp_rdata = (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
                3'd1:    v.exp_rdata = (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
                3'd2:    v.exp_rdata = d;
                3'd4:    v.exp_rdata = b;
                default: v.exp_rdata = h;
            endcase
            v.exp_err = (v.resp != 2'b00);
            v.exp_lat = 3 + v.ar_d + v.r_d;
            v.exp_ld = 1'b1;
            v.exp_baddr = v.addr - 32'(off);
        end else if (v.wen) begin
            v.exp_st = 1'b1;
            v.exp_baddr = v.addr - 32'(off);
            v.exp_wdata = v.wsrc << (8 * off);
            for (int j = 0; j < 4; j++)
                if (j >= off && v.wmask[j - off]) v.exp_wstrb[j] = 1'b1;
            v.exp_err = (v.resp != 2'b00);
            v.exp_lat = 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d;
        end
    endfunction

    task automatic clear_slave();
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    // Drives one request and acts as the AXI slave with the vector's delays.
    task automatic run_op(input vec_t v);
        int ar_wait = 0, aw_wait = 0, w_wait = 0, r_due = 0, b_due = 0, aw_k = 0, w_k = 0, done_k = 0;
        bit r_pend = 0, b_pend = 0;
        bit p_arv = 0, p_arhs = 0, p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0;
        logic [31:0] rd_addr = 32'd0;
        obs_ov = 0; obs_lat = 0; obs_ar = 0; obs_r = 0; obs_aw = 0; obs_w = 0; obs_b = 0;
        obs_rdata = 32'd0; obs_baddr = 32'd0; obs_wdata = 32'd0; obs_err = 1'b0; obs_wstrb = 4'd0;
        i_valid = 1'b1; i_addr = v.addr; i_wdata = v.wsrc; i_wmask = v.wmask;
        i_read_t = v.f3; i_mem_ren = v.ren; i_mem_wen = v.wen;
        for (int k = 1; k <= 40; k++) begin
            @(negedge i_clock);
            i_valid = 1'b0;
            if (p_arv && !p_arhs) check32("arvalid_hold", 32'(arvalid), 32'd1);
            if (p_arhs)           check32("arvalid_drop", 32'(arvalid), 32'd0);
            if (p_awv && !p_awhs) check32("awvalid_hold", 32'(awvalid), 32'd1);
            if (p_awhs)           check32("awvalid_drop", 32'(awvalid), 32'd0);
            if (p_wv && !p_whs)   check32("wvalid_hold", 32'(wvalid), 32'd1);
            if (p_whs)            check32("wvalid_drop", 32'(wvalid), 32'd0);
            if (done_k != 0) begin
                check32("o_valid_single", 32'(o_valid), 32'd0);
                break;
            end
            if (o_valid) begin
                obs_ov++; obs_lat = k; obs_rdata = o_rdata; obs_err = o_err; done_k = k;
            end
            arready = arvalid && (ar_wait >= v.ar_d);
            if (arvalid) ar_wait++;
            p_arv = arvalid; p_arhs = arvalid && arready;
            if (p_arhs) begin
                obs_ar++; obs_baddr = araddr; rd_addr = araddr; r_pend = 1; r_due = k + 1 + v.r_d;
            end
            rvalid = r_pend && (k >= r_due);
            rdata  = rvalid ? slave_mem[rd_addr[5:2]] : $urandom();
            rresp  = rvalid ? v.resp : 2'b00;
            if (rvalid && rready) begin r_pend = 0; obs_r++; end
            awready = awvalid && (aw_wait >= v.aw_d);
            if (awvalid) aw_wait++;
            p_awv = awvalid; p_awhs = awvalid && awready;
            if (p_awhs) begin obs_aw++; obs_baddr = awaddr; aw_k = k; end
            wready = wvalid && (w_wait >= v.w_d);
            if (wvalid) w_wait++;
            p_wv = wvalid; p_whs = wvalid && wready;
            if (p_whs) begin obs_w++; obs_wdata = wdata; obs_wstrb = wstrb; w_k = k; end
            if (obs_aw > 0 && obs_w > 0 && !b_pend && obs_b == 0) begin
                b_pend = 1; b_due = ((aw_k > w_k) ? aw_k : w_k) + 1 + v.b_d;
            end
            bvalid = b_pend && (k >= b_due);
            bresp  = bvalid ? v.resp : 2'b00;
            if (bvalid && bready) begin
                b_pend = 0; obs_b++;
                if (v.resp == 2'b00)
                    for (int j = 0; j < 4; j++)
                        if (obs_wstrb[j]) slave_mem[obs_baddr[5:2]][8*j +: 8] = obs_wdata[8*j +: 8];
            end
        end
        clear_slave();
    endtask

    task automatic check_op(input vec_t v, input string name);
        check32($sformatf("%s o_valid_count", name), 32'(obs_ov), 32'd1);
        check32($sformatf("%s latency", name), 32'(obs_lat), 32'(v.exp_lat));
        check32($sformatf("%s o_rdata", name), obs_rdata, v.exp_rdata);
        check32($sformatf("%s o_err", name), 32'(obs_err), 32'(v.exp_err));
        check32($sformatf("%s ar_beats", name), 32'(obs_ar), 32'(v.exp_ld));
        check32($sformatf("%s r_beats", name), 32'(obs_r), 32'(v.exp_ld));
        check32($sformatf("%s aw_beats", name), 32'(obs_aw), 32'(v.exp_st));
        check32($sformatf("%s w_beats", name), 32'(obs_w), 32'(v.exp_st));
        check32($sformatf("%s b_beats", name), 32'(obs_b), 32'(v.exp_st));
        if (v.exp_ld || v.exp_st) check32($sformatf("%s bus_addr", name), obs_baddr, v.exp_baddr);
        if (v.exp_st) begin
            check32($sformatf("%s wdata", name), obs_wdata, v.exp_wdata);
            check32($sformatf("%s wstrb", name), 32'(obs_wstrb), 32'(v.exp_wstrb));
            if (v.resp == 2'b00) model_write(v.addr, v.wsrc, v.wmask);
        end
    endtask

    initial begin
        vec_t v;
        int r;
        tbl[0]  = mk(1,0,32'h80000006,32'd0,4'd0,3'b000, 0,0,0,0,0,2'b00, 32'hFFFFFF99,1'b0,3,1'b1,1'b0,32'h80000004,32'd0,4'd0);
        tbl[1]  = mk(1,0,32'h80000006,32'd0,4'd0,3'b100, 0,0,0,0,0,2'b00, 32'h00000099,1'b0,3,1'b1,1'b0,32'h80000004,32'd0,4'd0);
        tbl[2]  = mk(1,0,32'h80000006,32'd0,4'd0,3'b101, 0,0,0,0,0,2'b00, 32'h00008899,1'b0,3,1'b1,1'b0,32'h80000004,32'd0,4'd0);
        tbl[3]  = mk(1,0,32'h80000004,32'd0,4'd0,3'b010, 2,1,0,0,0,2'b00, 32'h8899AABB,1'b0,6,1'b1,1'b0,32'h80000004,32'd0,4'd0);
        tbl[4]  = mk(1,0,32'h80000004,32'd0,4'd0,3'b001, 0,0,0,0,0,2'b00, 32'hFFFFAABB,1'b0,3,1'b1,1'b0,32'h80000004,32'd0,4'd0);
        tbl[5]  = mk(0,1,32'h80000003,32'h000000A5,4'b0001,3'b000, 0,0,0,0,0,2'b00, 32'd0,1'b0,3,1'b0,1'b1,32'h80000000,32'hA5000000,4'b1000);
        tbl[6]  = mk(0,1,32'h80000002,32'h00001234,4'b0011,3'b001, 0,0,0,0,0,2'b00, 32'd0,1'b0,3,1'b0,1'b1,32'h80000000,32'h12340000,4'b1100);
        tbl[7]  = mk(0,1,32'h80000008,32'hDEADBEEF,4'b1111,3'b010, 0,0,3,0,1,2'b00, 32'd0,1'b0,7,1'b0,1'b1,32'h80000008,32'hDEADBEEF,4'b1111);
        tbl[8]  = mk(0,1,32'h80000001,32'h0000005A,4'b0001,3'b000, 0,0,2,2,0,2'b00, 32'd0,1'b0,5,1'b0,1'b1,32'h80000000,32'h00005A00,4'b0010);
        tbl[9]  = mk(1,0,32'h80000002,32'd0,4'd0,3'b010, 0,0,0,0,0,2'b00, 32'd0,1'b1,1,1'b0,1'b0,32'd0,32'd0,4'd0);
        tbl[10] = mk(1,0,32'h80000004,32'd0,4'd0,3'b010, 0,0,0,0,0,2'b10, 32'h8899AABB,1'b1,3,1'b1,1'b0,32'h80000004,32'd0,4'd0);
        tbl[11] = mk(0,1,32'h80000000,32'h00000077,4'b0001,3'b000, 0,0,0,0,0,2'b11, 32'd0,1'b1,3,1'b0,1'b1,32'h80000000,32'h00000077,4'b0001);
        tbl[12] = mk(0,0,32'h80000010,32'h12345678,4'b1111,3'b010, 0,0,0,0,0,2'b00, 32'd0,1'b0,1,1'b0,1'b0,32'd0,32'd0,4'd0);
        tbl[13] = mk(1,1,32'h80000004,32'h12345678,4'b1111,3'b010, 0,0,0,0,0,2'b00, 32'd0,1'b1,1,1'b0,1'b0,32'd0,32'd0,4'd0);
        tbl[14] = mk(1,0,32'h80000004,32'd0,4'd0,3'b011, 0,0,0,0,0,2'b00, 32'd0,1'b1,1,1'b0,1'b0,32'd0,32'd0,4'd0);

        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = $urandom();
            model_mem[i] = slave_mem[i];
        end
        slave_mem[1] = 32'h8899AABB;
        model_mem[1] = 32'h8899AABB;

        i_reset = 1'b0; i_valid = 1'b0; i_addr = 32'd0; i_wdata = 32'd0;
        i_mem_ren = 1'b0; i_mem_wen = 1'b0; i_wmask = 4'd0; i_read_t = 3'd0;
        clear_slave();
        repeat (3) @(negedge i_clock);
        check32("reset o_valid", 32'(o_valid), 32'd0);
        check32("reset o_err", 32'(o_err), 32'd0);
        check32("reset o_rdata", o_rdata, 32'd0);
        check32("reset arvalid", 32'(arvalid), 32'd0);
        check32("reset rready", 32'(rready), 32'd0);
        check32("reset awvalid", 32'(awvalid), 32'd0);
        check32("reset wvalid", 32'(wvalid), 32'd0);
        check32("reset bready", 32'(bready), 32'd0);
        i_reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i]);
            check_op(tbl[i], $sformatf("vec%0d", i));
        end

        // Two non-memory instructions issued two cycles apart.
        run_op(tbl[12]);
        check_op(tbl[12], "b2b_first");
        run_op(tbl[12]);
        check_op(tbl[12], "b2b_second");

        // Reset while waiting for read data; a late rvalid must be ignored.
        run_op(tbl[3]);
        check_op(tbl[3], "pre_reset_lw");
        i_valid = 1'b1; i_mem_ren = 1'b1; i_mem_wen = 1'b0;
        i_addr = 32'h80000004; i_read_t = 3'b010;
        @(negedge i_clock);
        i_valid = 1'b0;
        check32("rst_seq arvalid", 32'(arvalid), 32'd1);
        arready = 1'b1;
        @(negedge i_clock);
        arready = 1'b0;
        check32("rst_seq rready", 32'(rready), 32'd1);
        i_reset = 1'b0;
        @(negedge i_clock);
        check32("rst_seq o_valid", 32'(o_valid), 32'd0);
        check32("rst_seq o_err", 32'(o_err), 32'd0);
        check32("rst_seq o_rdata", o_rdata, 32'd0);
        check32("rst_seq arvalid0", 32'(arvalid), 32'd0);
        check32("rst_seq rready0", 32'(rready), 32'd0);
        check32("rst_seq awvalid", 32'(awvalid), 32'd0);
        check32("rst_seq wvalid", 32'(wvalid), 32'd0);
        check32("rst_seq bready", 32'(bready), 32'd0);
        i_reset = 1'b1;
        rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b00;
        repeat (4) begin
            @(negedge i_clock);
            check32("stale_r o_valid", 32'(o_valid), 32'd0);
            check32("stale_r rready", 32'(rready), 32'd0);
        end
        clear_slave();
        run_op(tbl[12]);
        check_op(tbl[12], "post_reset");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            v.ren = (r >= 1 && r <= 5);
            v.wen = (r == 1 || r >= 6);
            v.addr = 32'h80000000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            v.wsrc = $urandom();
            r = int'($urandom_range(0, 2));
            v.wmask = (r == 0) ? 4'b0001 : (r == 1) ? 4'b0011 : 4'b1111;
            v.f3 = 3'($urandom_range(0, 7));
            v.ar_d = int'($urandom_range(0, 3)); v.r_d = int'($urandom_range(0, 3));
            v.aw_d = int'($urandom_range(0, 3)); v.w_d = int'($urandom_range(0, 3));
            v.b_d = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 7));
            v.resp = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : 2'b00;
            model_expect(v);
            run_op(v);
            check_op(v, $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
